// File: rtl/mem_stage.sv
// RV32I memory stage: aligns dmem requests, owns the MEM/WB register and the
// request/response FSM, and stalls the pipeline while writeback awaits dmem_resp.
module mem_stage #(
    parameter int PASS_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        in_mem_op,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_store_data,
    input  logic [PASS_W-1:0] in_payload,
    output logic              stall,
    output logic [31:0]       dmem_addr,
    output logic [3:0]        dmem_rmask,
    output logic [3:0]        dmem_wmask,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_resp,
    output logic              out_valid,
    output logic [3:0]        out_mem_op,
    output logic [31:0]       out_addr,
    output logic [3:0]        out_rmask,
    output logic [3:0]        out_wmask,
    output logic [31:0]       out_wdata,
    output logic [PASS_W-1:0] out_payload,
    output logic              out_misalign,
    output logic              out_pending
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic              pending_q, pending_d;
    logic              misalign_q, misalign_d;
    logic [3:0]        mem_op_q, mem_op_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        rmask_q, rmask_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [PASS_W-1:0] payload_q, payload_d;

    logic        is_load, is_store, misaligned, issue, spurious_resp;
    logic [1:0]  size;   // 0 byte, 1 half, 2 word
    logic [3:0]  lane_mask;
    logic [31:0] lane_data;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size     = 2'd0;
        case (in_mem_op)
            4'd1, 4'd4: begin is_load  = 1'b1; size = 2'd0; end
            4'd2, 4'd5: begin is_load  = 1'b1; size = 2'd1; end
            4'd3:       begin is_load  = 1'b1; size = 2'd2; end
            4'd8:       begin is_store = 1'b1; size = 2'd0; end
            4'd9:       begin is_store = 1'b1; size = 2'd1; end
            4'd10:      begin is_store = 1'b1; size = 2'd2; end
            default:    ;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        lane_mask  = 4'b1111;
        lane_data  = in_store_data;
        case (size)
            2'd0: begin
                lane_mask = 4'b0001 << in_addr[1:0];
                lane_data = {24'b0, in_store_data[7:0]} << {in_addr[1:0], 3'b000};
            end
            2'd1: begin
                misaligned = in_addr[0];
                lane_mask  = 4'b0011 << in_addr[1:0];
                lane_data  = {16'b0, in_store_data[15:0]} << {in_addr[1], 4'b0000};
            end
            default: misaligned = |in_addr[1:0];
        endcase
    end

    // Reset gates issue so no mask pulse escapes while rst is low.
    assign stall      = valid_q & pending_q & ~dmem_resp;
    assign issue      = rst & ~stall & in_valid & (is_load | is_store) & ~misaligned;
    assign dmem_addr  = {in_addr[31:2], 2'b00};
    assign dmem_rmask = (issue & is_load)  ? lane_mask : 4'b0000;
    assign dmem_wmask = (issue & is_store) ? lane_mask : 4'b0000;
    assign dmem_wdata = (issue & is_store) ? lane_data : 32'b0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = WAIT;
            WAIT:    if (dmem_resp) state_d = issue ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d    = valid_q;
        pending_d  = pending_q;
        misalign_d = misalign_q;
        mem_op_d   = mem_op_q;
        addr_d     = addr_q;
        rmask_d    = rmask_q;
        wmask_d    = wmask_q;
        wdata_d    = wdata_q;
        payload_d  = payload_q;
        if (!stall) begin
            valid_d    = in_valid;
            pending_d  = issue;
            misalign_d = in_valid & (is_load | is_store) & misaligned;
            mem_op_d   = in_mem_op;
            addr_d     = in_addr;
            rmask_d    = dmem_rmask;
            wmask_d    = dmem_wmask;
            wdata_d    = dmem_wdata;
            payload_d  = in_payload;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            pending_q  <= 1'b0;
            misalign_q <= 1'b0;
            mem_op_q   <= 4'b0;
            addr_q     <= 32'b0;
            rmask_q    <= 4'b0;
            wmask_q    <= 4'b0;
            wdata_q    <= 32'b0;
            payload_q  <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            pending_q  <= pending_d;
            misalign_q <= misalign_d;
            mem_op_q   <= mem_op_d;
            addr_q     <= addr_d;
            rmask_q    <= rmask_d;
            wmask_q    <= wmask_d;
            wdata_q    <= wdata_d;
            payload_q  <= payload_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pending  = pending_q;
    assign out_misalign = misalign_q;
    assign out_mem_op   = mem_op_q;
    assign out_addr     = addr_q;
    assign out_rmask    = rmask_q;
    assign out_wmask    = wmask_q;
    assign out_wdata    = wdata_q;
    assign out_payload  = payload_q;

    // A response with nothing outstanding (e.g. after a reset in WAIT) is ignored.
    assign spurious_resp = dmem_resp & ~pending_q;

    cover property (@(posedge clk) disable iff (!rst) spurious_resp);
    assert property (@(posedge clk) disable iff (!rst) (state_q == WAIT) == pending_q);

endmodule
